// File: rtl/icache_core_pkg.sv
// icache_core shared types: line geometry and one-hot controller states.
// Used by icache_core, icache_way and icache_core_if.
package icache_core_pkg;

  localparam int WayBus   = 256;
  localparam int BlockNum = 8;
  localparam int OFF_W    = 5;
  localparam int WSEL_W   = $clog2(BlockNum);

  typedef enum logic [4:0] {
    IDLE   = 5'b00001,
    LOOKUP = 5'b00010,
    MISS   = 5'b00100,
    REFILL = 5'b01000,
    DONE   = 5'b10000
  } state_t;

  function automatic logic [31:0] line_word(
    input logic [WayBus-1:0] line,
    input logic [WSEL_W-1:0] w
  );
    return line[{w, 5'b0} +: 32];
  endfunction

endpackage

// File: rtl/icache_core_if.sv
// icache_core bus bundle: fetch side plus line-refill side toward icache_axi.
// Perf counter outputs exist only with ICACHE_PERF_CNT_EN.
interface icache_core_if;

  logic         cpu_req;
  logic [31:0]  cpu_addr;
  logic         cpu_cached;
  logic         cpu_hold;
  logic         cpu_flush;
  logic         cpu_stall;
  logic         cpu_rvalid;
  logic [31:0]  cpu_rdata;
  logic         axi_req;
  logic [31:0]  axi_addr;
  logic         axi_rend;
  logic [255:0] axi_line;
`ifdef ICACHE_PERF_CNT_EN
  logic [31:0]  perf_hit;
  logic [31:0]  perf_miss;

  modport slave (
    input  cpu_req, cpu_addr, cpu_cached,
    input  cpu_hold, cpu_flush,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output axi_req, axi_addr,
    input  axi_rend, axi_line,
    output perf_hit, perf_miss
  );

  modport master (
    output cpu_req, cpu_addr, cpu_cached,
    output cpu_hold, cpu_flush,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  axi_req, axi_addr,
    output axi_rend, axi_line,
    input  perf_hit, perf_miss
  );
`else
  modport slave (
    input  cpu_req, cpu_addr, cpu_cached,
    input  cpu_hold, cpu_flush,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output axi_req, axi_addr,
    input  axi_rend, axi_line
  );

  modport master (
    output cpu_req, cpu_addr, cpu_cached,
    output cpu_hold, cpu_flush,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  axi_req, axi_addr,
    output axi_rend, axi_line
  );
`endif

endinterface

// File: rtl/icache_core_way.sv
// icache_way: valid/tag/data arrays of one cache way.
// Combinational read, synchronous write, flush clears all valid bits.
module icache_way
  import icache_core_pkg::*;
#(
  parameter int SETS = 64,
  parameter int IW   = $clog2(SETS),
  parameter int TW   = 32 - OFF_W - IW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [IW-1:0]     idx,
  input  logic [TW-1:0]     tag,
  output logic              hit,
  output logic [WayBus-1:0] line,
  input  logic              we,
  input  logic [WayBus-1:0] wline
);

  logic [SETS-1:0]   valid_q;
  logic [TW-1:0]     tag_q  [SETS];
  logic [WayBus-1:0] data_q [SETS];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        valid_q      <= '0;
    else if (flush) valid_q      <= '0;
    else if (we)    valid_q[idx] <= 1'b1;
  end

  // Tag/data carry no reset so they can map onto RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      tag_q[idx]  <= tag;
      data_q[idx] <= wline;
    end
  end

  assign hit  = valid_q[idx] && (tag_q[idx] == tag);
  assign line = data_q[idx];

endmodule

// File: rtl/icache_core.sv
// icache_core: 2-way set-associative I-cache in front of icache_axi.
// Define ICACHE_PERF_CNT_EN to add saturating hit/miss counters.
module icache_core
  import icache_core_pkg::*;
#(
  parameter int SETS = 64
) (
  input logic          aclk,
  input logic          areset,
  icache_core_if.slave bus
);

  localparam int IW = $clog2(SETS);
  localparam int TW = 32 - OFF_W - IW;

  state_t            state_q, state_d;
  logic [31:0]       addr_q;
  logic [31:0]       buf_q;
  logic [SETS-1:0]   lru_q;
  logic              flush_q;
  logic [1:0]        hit_w;
  logic [WayBus-1:0] line0, line1;
  logic              hit, accept, load, refill;
  logic              install, victim;
  logic [IW-1:0]     idx;
  logic [TW-1:0]     tag;
  logic [31:0]       hit_word;
  logic              unused_lo;

  assign idx       = addr_q[OFF_W +: IW];
  assign tag       = addr_q[31 -: TW];
  assign victim    = lru_q[idx];
  assign unused_lo = ^addr_q[1:0];
  assign hit       = (|hit_w) && !bus.cpu_flush;
  assign accept    = bus.cpu_req && bus.cpu_cached;
  assign hit_word  = line_word(hit_w[0] ? line0 : line1,
                               addr_q[4:2]);
  assign refill    = (state_q == REFILL) && bus.axi_rend;
  assign install   = refill && !bus.cpu_flush && !flush_q;

  icache_way #(.SETS(SETS)) u_way0 (
    .clk   (aclk),
    .rst   (areset),
    .flush (bus.cpu_flush),
    .idx   (idx),
    .tag   (tag),
    .hit   (hit_w[0]),
    .line  (line0),
    .we    (install && !victim),
    .wline (bus.axi_line)
  );

  icache_way #(.SETS(SETS)) u_way1 (
    .clk   (aclk),
    .rst   (areset),
    .flush (bus.cpu_flush),
    .idx   (idx),
    .tag   (tag),
    .hit   (hit_w[1]),
    .line  (line1),
    .we    (install && victim),
    .wline (bus.axi_line)
  );

  always_comb begin
    state_d        = state_q;
    load           = 1'b0;
    bus.cpu_stall  = 1'b0;
    bus.cpu_rvalid = 1'b0;
    bus.cpu_rdata  = '0;
    bus.axi_req    = 1'b0;
    bus.axi_addr   = '0;
    unique case (1'b1)
      (state_q == IDLE): begin
        if (accept) begin
          load    = 1'b1;
          state_d = LOOKUP;
        end
      end
      (state_q == LOOKUP): begin
        if (hit) begin
          bus.cpu_rvalid = 1'b1;
          bus.cpu_rdata  = hit_word;
          if (!bus.cpu_hold) begin
            load    = accept;
            state_d = accept ? LOOKUP : IDLE;
          end
        end else begin
          bus.cpu_stall = 1'b1;
          state_d       = MISS;
        end
      end
      (state_q == MISS): begin
        bus.cpu_stall = 1'b1;
        bus.axi_req   = 1'b1;
        bus.axi_addr  = {addr_q[31:5], 5'b0};
        state_d       = REFILL;
      end
      (state_q == REFILL): begin
        bus.cpu_stall = 1'b1;
        if (bus.axi_rend) state_d = DONE;
      end
      (state_q == DONE): begin
        bus.cpu_rvalid = 1'b1;
        bus.cpu_rdata  = buf_q;
        if (!bus.cpu_hold) begin
          load    = accept;
          state_d = accept ? LOOKUP : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      buf_q   <= '0;
      lru_q   <= '0;
      flush_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) addr_q <= bus.cpu_addr;
      if (refill) buf_q <= line_word(bus.axi_line, addr_q[4:2]);
      if ((state_q == LOOKUP) && hit) lru_q[idx] <= hit_w[0];
      if (install) lru_q[idx] <= !victim;
      // A flush while the refill is in flight blocks its install.
      if (refill)
        flush_q <= 1'b0;
      else if (bus.cpu_flush &&
               (state_q == MISS || state_q == REFILL))
        flush_q <= 1'b1;
    end
  end

`ifdef ICACHE_PERF_CNT_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;
  logic        held_q, look;

  assign look          = (state_q == LOOKUP);
  assign bus.perf_hit  = hit_cnt_q;
  assign bus.perf_miss = miss_cnt_q;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      held_q     <= 1'b0;
    end else begin
      held_q <= look && hit && bus.cpu_hold;
      if (look && hit && !held_q && hit_cnt_q != '1)
        hit_cnt_q <= hit_cnt_q + 32'd1;
      if (look && !hit && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_icache_core.sv
// Bench for icache_core: directed scenarios plus random fetches
// checked against a line-level 2-way LRU cache model.
module tb_icache_core;

  logic aclk = 1'b0;
  logic areset;
  int   tests = 0;
  int   fails = 0;
  int   reqs  = 0;

  icache_core_if bus ();

  icache_core #(.SETS(64)) u_dut (
    .aclk   (aclk),
    .areset (areset),
    .bus    (bus)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) if (bus.axi_req === 1'b1) reqs++;

  bit          mv   [2][64];
  logic [26:0] mla  [2][64];
  bit          mlru [64];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h1000_0004) return 32'hDEAD_BEEF;
    return {a[15:0], a[31:16]} ^ 32'hC3C3_1234;
  endfunction

  function automatic logic [255:0] make_line(input logic [26:0] la);
    logic [255:0] l;
    for (int k = 0; k < 8; k++)
      l[32*k +: 32] = mem_word({la, 5'(k * 4)});
    return l;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 64; s++) begin
      mv[0][s] = 0;
      mv[1][s] = 0;
      mlru[s]  = 0;
    end
  endfunction

  function automatic void model_flush();
    for (int s = 0; s < 64; s++) begin
      mv[0][s] = 0;
      mv[1][s] = 0;
    end
  endfunction

  function automatic int model_way(input logic [31:0] a);
    int s = int'(a[10:5]);
    for (int w = 0; w < 2; w++)
      if (mv[w][s] && mla[w][s] == a[31:5]) return w;
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // fl: 0 none, 1 flush with axi_rend, 2 flush in first wait cycle
  task automatic fetch(input logic [31:0] a, input int dly_in,
                       input int fl);
    int s = int'(a[10:5]);
    int w = model_way(a);
    int dly = dly_in;
    int v;
    logic [31:0] exp_w = mem_word({a[31:2], 2'b0});
    if (fl == 2 && dly == 0) dly = 1;
    @(negedge aclk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    @(negedge aclk);
    bus.cpu_req  = 1'b0;
    if (w >= 0) begin
      chk("hit_rvalid", 32'(bus.cpu_rvalid), 1);
      chk("hit_stall", 32'(bus.cpu_stall), 0);
      chk("hit_rdata", bus.cpu_rdata, exp_w);
      mlru[s] = (w == 0);
    end else begin
      chk("miss_stall", 32'(bus.cpu_stall), 1);
      chk("miss_rvalid", 32'(bus.cpu_rvalid), 0);
      @(negedge aclk);
      chk("axi_req", 32'(bus.axi_req), 1);
      chk("axi_addr", bus.axi_addr, {a[31:5], 5'b0});
      @(negedge aclk);
      for (int i = 0; i < dly; i++) begin
        chk("refill_stall", 32'(bus.cpu_stall), 1);
        chk("refill_noreq", 32'(bus.axi_req), 0);
        if (fl == 2 && i == 0) bus.cpu_flush = 1'b1;
        @(negedge aclk);
        bus.cpu_flush = 1'b0;
      end
      bus.axi_rend  = 1'b1;
      bus.axi_line  = make_line(a[31:5]);
      bus.cpu_flush = (fl == 1);
      @(negedge aclk);
      bus.axi_rend  = 1'b0;
      bus.cpu_flush = 1'b0;
      bus.axi_line  = '0;
      chk("done_rvalid", 32'(bus.cpu_rvalid), 1);
      chk("done_stall", 32'(bus.cpu_stall), 0);
      chk("done_rdata", bus.cpu_rdata, exp_w);
      if (fl != 0) begin
        model_flush();
      end else begin
        v = mlru[s] ? 1 : 0;
        mv[v][s]  = 1;
        mla[v][s] = a[31:5];
        mlru[s]   = (v == 0);
      end
    end
  endtask

  initial begin
    int r0;
    int w;
    logic [31:0] a;
    areset         = 1'b1;
    bus.cpu_req    = 1'b0;
    bus.cpu_addr   = '0;
    bus.cpu_cached = 1'b1;
    bus.cpu_hold   = 1'b0;
    bus.cpu_flush  = 1'b0;
    bus.axi_rend   = 1'b0;
    bus.axi_line   = '0;
    model_reset();
    @(negedge aclk);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("rst_axi_req", 32'(bus.axi_req), 0);
    chk("rst_rdata", bus.cpu_rdata, 0);
    chk("rst_axi_addr", bus.axi_addr, 0);
    areset = 1'b0;

    // Cold fetch returns the word1 of the refilled line
    fetch(32'h1000_0004, 2, 0);

    // Eight back-to-back hits, no refill traffic
    r0 = reqs;
    @(negedge aclk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h1000_0000;
    for (int k = 0; k < 8; k++) begin
      a = 32'h1000_0000 + 32'(4 * k);
      w = model_way(a);
      @(negedge aclk);
      chk("b2b_rvalid", 32'(bus.cpu_rvalid), 1);
      chk("b2b_rdata", bus.cpu_rdata, mem_word(a));
      if (w >= 0) mlru[0] = (w == 0);
      if (k < 7) bus.cpu_addr = a + 32'd4;
      else bus.cpu_req = 1'b0;
    end
    chk("b2b_no_axi_req", 32'(reqs - r0), 0);

    // Held hit stays frozen and ignores a new request
    r0 = reqs;
    a  = 32'h1000_0008;
    w  = model_way(a);
    @(negedge aclk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = a;
    @(negedge aclk);
    bus.cpu_hold = 1'b1;
    bus.cpu_addr = 32'h1000_0010;
    chk("hold_pre_rvalid", 32'(bus.cpu_rvalid), 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      chk("hold_rvalid", 32'(bus.cpu_rvalid), 1);
      chk("hold_rdata", bus.cpu_rdata, mem_word(a));
    end
    bus.cpu_hold = 1'b0;
    bus.cpu_req  = 1'b0;
    @(negedge aclk);
    chk("hold_not_accepted", 32'(bus.cpu_rvalid), 0);
    chk("hold_no_axi_req", 32'(reqs - r0), 0);
    if (w >= 0) mlru[0] = (w == 0);

    // Uncached request is ignored
    bus.cpu_req    = 1'b1;
    bus.cpu_cached = 1'b0;
    bus.cpu_addr   = 32'h3000_0000;
    @(negedge aclk);
    bus.cpu_req    = 1'b0;
    bus.cpu_cached = 1'b1;
    chk("uncached_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("uncached_stall", 32'(bus.cpu_stall), 0);

    // Three tags into set 0: LRU eviction
    fetch(32'h0000_0000, 0, 0);
    fetch(32'h0000_0800, 1, 0);
    fetch(32'h0000_1000, 0, 0);
    chk("lru_evicted", 32'(model_way(32'h0)), 32'hFFFF_FFFF);
    fetch(32'h0000_0000, 1, 0);

    // Flush during refill: data returned, line not installed
    fetch(32'h0000_2040, 2, 2);
    fetch(32'h0000_2040, 0, 0);
    fetch(32'h0000_3044, 1, 1);
    fetch(32'h0000_3044, 0, 0);

    // areset in REFILL aborts everything
    @(negedge aclk);
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 32'h2000_0040;
    @(negedge aclk);
    bus.cpu_req  = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    chk("pre_rst_stall", 32'(bus.cpu_stall), 1);
    areset = 1'b1;
    #1;
    chk("arst_stall", 32'(bus.cpu_stall), 0);
    chk("arst_rvalid", 32'(bus.cpu_rvalid), 0);
    chk("arst_axi_req", 32'(bus.axi_req), 0);
    chk("arst_rdata", bus.cpu_rdata, 0);
    chk("arst_axi_addr", bus.axi_addr, 0);
    @(negedge aclk);
    areset = 1'b0;
    model_reset();
    fetch(32'h2000_0040, 1, 0);
    fetch(32'h1000_0004, 0, 0);

    // Random fetches over a small conflicting footprint
    for (int i = 0; i < 60; i++) begin
      int fl = 0;
      a = 32'h4000_0000
        | (32'($urandom_range(0, 3)) << 11)
        | (32'($urandom_range(0, 3)) << 5)
        | (32'($urandom_range(0, 7)) << 2);
      if ($urandom_range(0, 9) == 0) fl = int'($urandom_range(1, 2));
      fetch(a, int'($urandom_range(0, 3)), fl);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_core.md
# icache_core

Two-way set-associative instruction cache sitting directly upstream of `icache_axi`. It serves fetch-stage requests from internal tag/data arrays. On a miss it issues a one-cycle line-refill request (`icache_axi_req_i`/`icache_axi_addr_i`) and installs the returned 256-bit line when `icache_axi_rend` pulses. Uncached fetches are not handled here; they bypass to `icache_axi`.

## Interface
- `SETS`, 64: sets per way; power of two, 2..256.
- `aclk` in 1: clock, rising edge.
- `areset` in 1: asynchronous, active-high reset. The block has one clock.
- `cpu_req` in 1: fetch request; accepted when `cpu_stall`=0.
- `cpu_addr` in 32: fetch byte address; bits [1:0] are ignored.
- `cpu_cached` in 1: 0 means the request is ignored by this block.
- `cpu_hold` in 1: pipeline stall; freezes the response.
- `cpu_flush` in 1: invalidate all lines.
- `cpu_stall` out 1: cache busy; the request is not accepted.
- `cpu_rvalid` out 1: `cpu_rdata` is valid this cycle.
- `cpu_rdata` out 32: instruction word.
- `axi_req` out 1: refill request pulse (to `icache_axi_req_i`).
- `axi_addr` out 32: line-aligned refill address, [4:0]=0.
- `axi_rend` in 1: refill done (from `icache_axi_rend`).
- `axi_line` in 256: refill data (from `icache_axi_data_o`); word k is at [32k+31:32k].

## Operation
- Address split: offset [4:0], word [4:2], index [4+log2(SETS):5], tag is the remaining upper bits.
- Per set and per way the arrays hold: valid, tag, 256-bit line. Each set also has one LRU bit giving the victim way.
- States: IDLE, LOOKUP, MISS, REFILL, DONE.
- IDLE
  - `cpu_req` & `cpu_cached`: register the address and go to LOOKUP.
  - Otherwise stay in IDLE.
- LOOKUP
  - Read both ways combinationally on the registered address and compare tags.
  - Hit: `cpu_rvalid`=1 and `cpu_rdata`=hit word. Set LRU to the other way.
  - Hit with a new accepted request: stay in LOOKUP with the new address. Hit without one: go to IDLE.
  - Miss: go to MISS with `cpu_stall`=1.
- MISS
  - `axi_req`=1 for exactly one cycle, with `axi_addr`={addr[31:5],5'b0}.
  - Go to REFILL.
- REFILL
  - `cpu_stall`=1 while waiting for `axi_rend`.
  - On `axi_rend`:
    - Write `axi_line`, the tag and valid=1 into the LRU way.
    - Flip LRU.
    - Latch the line into the response buffer.
    - Go to DONE.
- DONE
  - `cpu_rvalid`=1 and `cpu_rdata`=buffered word.
  - Accepts a new request exactly as a LOOKUP hit does.
- `cpu_stall` is 1 in MISS and REFILL, and in LOOKUP on a miss. It is 0 otherwise.
- `cpu_hold`=1 in LOOKUP-hit or DONE: state, `cpu_rvalid` and `cpu_rdata` stay unchanged and no new request is accepted.
- `cpu_hold` does not delay an outstanding refill.
- `cpu_flush`
  - Clears every valid bit next edge, from any state.
  - A refill in progress completes and is returned to the CPU, but is not installed: valid stays 0.
  - A LOOKUP in the flush cycle is forced to miss.
- `cpu_cached`=0 requests: no state change and no response.

## Timing
- Reset values:
  - State IDLE; all valid and LRU bits 0.
  - `cpu_stall`, `cpu_rvalid`, `axi_req` all 0; `cpu_rdata`=0; `axi_addr`=0.
- Hit latency: 1 cycle (request edge to `cpu_rvalid`). Back-to-back hits sustain 1 word/cycle.
- Miss latency: 3 cycles + refill latency. Sequence: LOOKUP, MISS, REFILL (≥1 cycle, until `axi_rend`), DONE.
- `axi_req` never reasserts before `axi_rend` for the previous request.
- `axi_rend` outside REFILL is ignored.
- An `areset` assertion mid-refill aborts immediately. The `icache_axi` reset is asserted at the same time.
- Flush and `axi_rend` in the same cycle: data goes to the CPU and the line is not installed.

## Configuration
- `ICACHE_PERF_CNT_EN` defined:
  - Adds outputs `perf_hit` (32) and `perf_miss` (32). These are saturating counters, incremented on each LOOKUP hit/miss and reset to 0.
  - A cycle held by `cpu_hold` does not count again.
- `ICACHE_PERF_CNT_EN` undefined: these ports and counters do not exist.

## Structure
- Shared package/defines:
  - Line width 256 (`WayBus`), words per line 8 (`BlockNum`).
  - State encodings: one-hot, 5 bits.
  - Offset width 5.
- One sub-module `icache_way`: valid/tag/data arrays for one way, with combinational read, synchronous write and flush clear. It is instantiated twice.

## Test plan
- Cold fetch 0x1000_0004 → `axi_req` pulse with `axi_addr`=0x1000_0000. `axi_rend` returns a line with word1=0xDEAD_BEEF → `cpu_rdata`=0xDEAD_BEEF in DONE.
- Refetch 0x1000_0000–0x1000_001C back-to-back → 8 consecutive hit cycles with no `axi_req`.
- SETS=64, three tags in the same set (0x0000_0000, 0x0000_0800, 0x0000_1000): the third evicts the first (LRU). Refetch of 0x0 → miss.
- Assert `cpu_flush` during REFILL → word returned; the next fetch of the same address misses again.
- Hit with `cpu_hold`=1 for 3 cycles → `cpu_rvalid`/`cpu_rdata` stable and no new request accepted.
- Assert `areset` in REFILL → all outputs 0 and state IDLE. The next fetch misses.
